// File: rtl/sblock_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : sblock_cfg_loader
// Purpose : Serial-to-parallel config writer for a chain of Sblock switch
//           boxes; optional per-word even parity when CFG_PARITY_EN is defined.
// Rev     : 1.0
// ============================================================================
module sblock_cfg_loader #(
   parameter int NUM_BLOCKS = 4,
   parameter int WR_PULSE   = 2,
   parameter int WORD_W     = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  cfg_valid,
   input  logic                  cfg_data,
   output logic                  cfg_ready,
   output logic [WORD_W-1:0]     cfg_bits,
   output logic [NUM_BLOCKS-1:0] wr_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int CNT_W = $clog2(WORD_W + 2);
   localparam int PUL_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
`ifdef CFG_PARITY_EN
   localparam int BITS_PER_WORD = WORD_W + 1;
`else
   localparam int BITS_PER_WORD = WORD_W;
`endif
   localparam logic [CNT_W-1:0] c_last_bit   = CNT_W'(BITS_PER_WORD - 1);
   localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_BLOCKS - 1);
   localparam logic [PUL_W-1:0] c_last_pulse = PUL_W'(WR_PULSE - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SHIFT  = 3'd1,
      SETUP  = 3'd2,
      STROBE = 3'd3,
      HOLD   = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t                  state_q,     state_d;
   logic [WORD_W-1:0]       shreg_q,     shreg_d;
   logic [WORD_W-1:0]       cfg_bits_q,  cfg_bits_d;
   logic [NUM_BLOCKS-1:0]   wr_en_q,     wr_en_d;
   logic [IDX_W-1:0]        idx_q,       idx_d;
   logic [CNT_W-1:0]        bit_cnt_q,   bit_cnt_d;
   logic [PUL_W-1:0]        pulse_cnt_q, pulse_cnt_d;
   logic                    cfg_ready_q, cfg_ready_d;
   logic                    busy_q,      busy_d;
   logic                    done_q,      done_d;
   logic                    xfer;
   logic                    skip_strobe;
   logic                    is_par_bit;
`ifdef CFG_PARITY_EN
   logic                    par_acc_q,   par_acc_d;
   logic                    skip_q,      skip_d;
   logic                    err_q,       err_d;

   assign is_par_bit  = (bit_cnt_q == c_last_bit);
   assign skip_strobe = skip_q;
   assign err         = err_q;
`else
   assign is_par_bit  = 1'b0;
   assign skip_strobe = 1'b0;
   assign err         = 1'b0;
`endif

   assign xfer = cfg_valid && cfg_ready_q;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cfg_bits_d  = cfg_bits_q;
      idx_d       = idx_q;
      bit_cnt_d   = bit_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      wr_en_d     = '0;
`ifdef CFG_PARITY_EN
      par_acc_d   = par_acc_q;
      skip_d      = skip_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = SHIFT;
               idx_d     = '0;
               bit_cnt_d = '0;
`ifdef CFG_PARITY_EN
               err_d     = 1'b0;
`endif
            end
         end
         SHIFT: begin
            if (xfer) begin
               if (!is_par_bit) begin
                  shreg_d = {shreg_q[WORD_W-2:0], cfg_data};
               end
`ifdef CFG_PARITY_EN
               par_acc_d = ((bit_cnt_q == '0) ? 1'b0 : par_acc_q) ^ cfg_data;
`endif
               if (bit_cnt_q == c_last_bit) begin
                  state_d   = SETUP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         SETUP: begin
            cfg_bits_d  = shreg_q;
            pulse_cnt_d = '0;
            state_d     = STROBE;
`ifdef CFG_PARITY_EN
            // par_acc holds XOR of word and parity bit: nonzero means corrupt
            skip_d = par_acc_q;
            err_d  = err_q | par_acc_q;
`endif
         end
         STROBE: begin
            // wr_en is registered from this state, so it lags the state by one
            // cycle; that lag provides the one-cycle setup margin after SETUP.
            if (!skip_strobe) begin
               wr_en_d = NUM_BLOCKS'(1) << idx_q;
            end
            if (pulse_cnt_q == c_last_pulse) begin
               state_d = HOLD;
            end else begin
               pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (idx_q == c_last_idx) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cfg_ready_d = (state_d == SHIFT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cfg_bits_q  <= '0;
         wr_en_q     <= '0;
         idx_q       <= '0;
         bit_cnt_q   <= '0;
         pulse_cnt_q <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef CFG_PARITY_EN
         par_acc_q   <= 1'b0;
         skip_q      <= 1'b0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cfg_bits_q  <= cfg_bits_d;
         wr_en_q     <= wr_en_d;
         idx_q       <= idx_d;
         bit_cnt_q   <= bit_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef CFG_PARITY_EN
         par_acc_q   <= par_acc_d;
         skip_q      <= skip_d;
         err_q       <= err_d;
`endif
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign cfg_bits  = cfg_bits_q;
   assign wr_en     = wr_en_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sblock_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_sblock_cfg_loader
// Purpose : Randomized self-checking bench for sblock_cfg_loader with a
//           queue-based reference model of the expected strobe sequence.
// Rev     : 1.0
// ============================================================================
module tb_sblock_cfg_loader;
   localparam int NUM_BLOCKS = 3;
   localparam int WR_PULSE   = 2;
   localparam int WORD_W     = 18;
`ifdef CFG_PARITY_EN
   localparam int BPW = WORD_W + 1;
`else
   localparam int BPW = WORD_W;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  cfg_valid = 1'b0;
   logic                  cfg_data = 1'b0;
   logic                  cfg_ready;
   logic [WORD_W-1:0]     cfg_bits;
   logic [NUM_BLOCKS-1:0] wr_en;
   logic                  busy;
   logic                  done;
   logic                  err;

   sblock_cfg_loader #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .WR_PULSE   (WR_PULSE),
      .WORD_W     (WORD_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .cfg_bits  (cfg_bits),
      .wr_en     (wr_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                blk;
      logic [WORD_W-1:0] word;
   } exp_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   logic bitq[$];
   bit   good_q[$];
   exp_t exp_q[$];
   int   rise_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: counts accepted bits, matches strobes against the expected list
   logic [NUM_BLOCKS-1:0] prev_wr   = '0;
   logic [WORD_W-1:0]     prev_bits = '0;
   int                    mon_bits  = 0;
   int                    pulse_len = 0;

   always @(negedge clk) begin
      if (rst) begin
         mon_bits  = 0;
         pulse_len = 0;
         prev_wr   = '0;
         prev_bits = cfg_bits;
         good_q.delete();
         exp_q.delete();
         rise_q.delete();
      end else begin
         if (cfg_valid && cfg_ready) begin
            mon_bits++;
            if (mon_bits == BPW) begin
               mon_bits = 0;
               if (good_q.size() == 0) check_eq("extra_word", 1, 0);
               else if (good_q.pop_front()) rise_q.push_back(cyc + 3);
            end
         end
         if (cfg_bits != prev_bits)
            check_eq("bits_stable", {31'd0, (wr_en == '0 && prev_wr == '0)}, 1);
         if (wr_en != '0) begin
            check_eq("onehot", $countones(wr_en), 1);
            check_eq("ready_low_in_strobe", {31'd0, cfg_ready}, 0);
         end
         if (wr_en != '0 && prev_wr == '0) begin
            int   idx;
            exp_t e;
            idx = -1;
            for (int i = 0; i < NUM_BLOCKS; i++) if (wr_en[i]) idx = i;
            pulse_len = 1;
            if (exp_q.size() == 0) check_eq("unexpected_strobe", 1, 0);
            else begin
               e = exp_q.pop_front();
               check_eq("strobe_blk", idx, e.blk);
               check_eq("strobe_word", {14'd0, cfg_bits}, {14'd0, e.word});
            end
            if (rise_q.size() == 0) check_eq("rise_without_word", 1, 0);
            else check_eq("strobe_latency", cyc, rise_q.pop_front());
         end else if (wr_en != '0) begin
            check_eq("strobe_steady", {29'd0, wr_en}, {29'd0, prev_wr});
            pulse_len++;
         end else if (prev_wr != '0) begin
            check_eq("pulse_len", pulse_len, WR_PULSE);
         end
         if (done) done_cnt++;
         prev_wr   = wr_en;
         prev_bits = cfg_bits;
      end
   end

   task automatic send_bits(input int n, input int stall_pct, input bit poke);
      bit acc;
      int guard;
      for (int i = 0; i < n; i++) begin
         guard = 0;
         forever begin
            cfg_data  = bitq[i];
            cfg_valid = ($urandom_range(0, 99) >= stall_pct);
            start     = poke && ($urandom_range(0, 5) == 0);
            @(negedge clk);
            acc = cfg_valid && cfg_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) break;
            guard++;
            if (guard > 200) begin
               check_eq("bit_timeout", 1, 0);
               return;
            end
         end
      end
      // leave a stray bit offered; it must not be consumed outside SHIFT
      cfg_valid = 1'b1;
      cfg_data  = 1'($urandom);
   endtask

   task automatic build_pass(input bit fixed, output bit any_bad);
      logic [WORD_W-1:0] w;
      logic              pb;
      bit                good;
      logic [WORD_W-1:0] fixed_w[3] = '{18'h2AAAA, 18'h1FF00, 18'h3FFFF};
      any_bad = 0;
      bitq.delete();
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         w    = fixed ? fixed_w[b % 3] : WORD_W'($urandom);
         pb   = ^w;
         good = 1;
`ifdef CFG_PARITY_EN
         if (!fixed && $urandom_range(0, 3) == 0) begin
            pb   = ~pb;
            good = 0;
         end
`endif
         if (!good) any_bad = 1;
         good_q.push_back(good);
         if (good) exp_q.push_back('{b, w});
         for (int j = WORD_W - 1; j >= 0; j--) bitq.push_back(w[j]);
`ifdef CFG_PARITY_EN
         bitq.push_back(pb);
`endif
      end
   endtask

   task automatic run_pass(input int stall_pct, input bit poke, input bit fixed);
      bit any_bad;
      int guard;
      build_pass(fixed, any_bad);
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("busy_after_start", {31'd0, busy}, 1);
      send_bits(bitq.size(), stall_pct, poke);
      guard = 0;
      while (done_cnt == 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check_eq("done_seen", {31'd0, (done_cnt > 0)}, 1);
      repeat (3) @(negedge clk);
      check_eq("done_once", done_cnt, 1);
      check_eq("busy_clear", {31'd0, busy}, 0);
      check_eq("strobes_all_seen", exp_q.size(), 0);
      check_eq("err_flag", {31'd0, err}, {31'd0, any_bad});
      check_eq("ready_idle", {31'd0, cfg_ready}, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      bit unused_bad;
      int guard;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_wr_en", {29'd0, wr_en}, 0);
      check_eq("rst_bits", {14'd0, cfg_bits}, 0);
      check_eq("rst_busy", {31'd0, busy}, 0);
      check_eq("rst_ready", {31'd0, cfg_ready}, 0);
      check_eq("rst_done", {31'd0, done}, 0);
      check_eq("rst_err", {31'd0, err}, 0);
      @(posedge clk); #1;
      rst       = 1'b0;
      cfg_valid = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("idle_ignores_valid", {31'd0, cfg_ready}, 0);
      @(posedge clk); #1;

      run_pass(0, 0, 1);
      run_pass(30, 0, 0);
      run_pass(20, 1, 0);

      // reset in the middle of the first strobe
      build_pass(0, unused_bad);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      send_bits(BPW, 0, 0);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (wr_en == '0 && guard < 20);
      check_eq("strobe_before_rst", {31'd0, (wr_en != '0)}, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_wr_en", {29'd0, wr_en}, 0);
      check_eq("midrst_busy", {31'd0, busy}, 0);
      check_eq("midrst_bits", {14'd0, cfg_bits}, 0);
      check_eq("midrst_ready", {31'd0, cfg_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int p = 0; p < 4; p++) run_pass(25, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/sblock_cfg_loader.md
Name: sblock_cfg_loader

Overview:
- Configuration writer for a chain of Sblock switch boxes.
- Accepts a serial bitstream over a valid/ready handshake and assembles one 18-bit routing word per Sblock: H dots in [17:9], V dots in [8:0].
- Drives a shared 18-bit config bus and a one-hot wr_en strobe so each Sblock's high-enable latches capture a clean, stable word.
- Sits between the top-level programming port and the Sblock array.

Parameters:
- NUM_BLOCKS, 4, number of Sblocks addressed; one wr_en bit each; must be >= 1.
- WR_PULSE, 2, number of cycles each wr_en strobe stays high; must be >= 1.
- WORD_W, 18, config word width per Sblock; fixed at 18 for this fabric.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a full programming pass; honoured only in IDLE.
- cfg_valid  input  1  serial bit on cfg_data is valid.
- cfg_data  input  1  serial config bit, MSB of each word first.
- cfg_ready  output  1  loader accepts a bit this cycle.
- cfg_bits  output  WORD_W  shared config bus to all Sblock bits inputs.
- wr_en  output  NUM_BLOCKS  one-hot latch-enable strobes; bit i goes to Sblock i.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when a pass completes.
- err  output  1  sticky error flag; always 0 unless CFG_PARITY_EN is defined.

Behaviour:
- Reset, synchronous on the clk edge with rst=1: state=IDLE, cfg_bits=0, wr_en=0, cfg_ready=0, busy=0, done=0, err=0, block index=0, bit counter=0. Reset asserted mid-pass drops wr_en at that same edge; no partial word is ever strobed after reset.
- A bit transfers only on a cycle with cfg_valid && cfg_ready. Stalls (cfg_valid=0) are allowed at any point; counters hold during a stall.
- FSM states:
  - IDLE: cfg_ready=0. start=1 → SHIFT; index and bit count are cleared. start is ignored in every other state.
  - SHIFT: cfg_ready=1. Each transfer shifts the shift register left and inserts cfg_data at the LSB. The transfer of bit WORD_W (count WORD_W-1) → SETUP.
  - SETUP: exactly 1 cycle. cfg_ready=0; cfg_bits is loaded with the assembled word; wr_en=0.
  - STROBE: WR_PULSE cycles with wr_en[index]=1 and all other wr_en bits 0. cfg_bits holds.
  - HOLD: 1 cycle with wr_en=0 and cfg_bits still holding (latch hold time). If index==NUM_BLOCKS-1 → DONE; otherwise index+1 → SHIFT.
  - DONE: 1 cycle, done=1, then → IDLE. cfg_bits keeps its last value until the next SETUP or reset.
- Latency: with the last bit of a word accepted at edge k, cfg_bits updates at edge k+1, wr_en rises at edge k+2, and wr_en falls at edge k+2+WR_PULSE.
- cfg_bits is never changed while any wr_en bit is high or during the cycle immediately before or after a strobe.
- Block order: block 0 first. Total payload is NUM_BLOCKS*WORD_W bits; no header.
- Bits offered with cfg_valid=1 outside SHIFT are not consumed (cfg_ready=0).
- NUM_BLOCKS=1: HOLD goes directly to DONE.

Optional Feature:
- Macro: CFG_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit; SHIFT consumes WORD_W+1 bits.
  - The parity bit is XORed with the reduction-XOR of the word.
  - On mismatch, STROBE is skipped: wr_en stays 0 for that block, but SETUP and HOLD timing is unchanged. err sets and stays set until the next accepted start or reset.
  - The pass continues to the remaining blocks.
- Not defined: no parity bit is consumed, err is tied 0, and no check logic is present.

Test Plan:
- Reset behaviour: assert rst mid-STROBE → at that edge wr_en=0, busy=0, cfg_bits=0, state IDLE; the next start runs a full pass normally.
- Single word, NUM_BLOCKS=2, WR_PULSE=2: stream 0x2AAAA then 0x1FF00 with no stalls → cfg_bits=0x2AAAA while wr_en=01 for exactly 2 cycles; then 0x1FF00 with wr_en=10 for 2 cycles; done pulses once; busy clears.
- Backpressure: drop cfg_valid for 5 cycles mid-word → assembled word unchanged (0x2AAAA); strobe timing measured from the last accepted bit is still k+2.
- Setup/hold check: assert cfg_bits is stable from 1 cycle before every wr_en rise to 1 cycle after every fall, and wr_en is never more than one-hot.
- start during busy, pulsed in SHIFT and in STROBE → ignored; exactly NUM_BLOCKS strobes occur and one done.
- With CFG_PARITY_EN: word 0x00001 with parity bit 0 → no wr_en[0] strobe and err=1; next word 0x00003 with parity 0 → wr_en[1] strobes, and err remains 1 until the next start.
